// File: rtl/uart_regmap_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_regmap_master
// Purpose  : Frames one regmap read/write command for uart_tx and collects the
//            read reply from uart_rx. Optional macro REGMAP_MASTER_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_regmap_master #(
  parameter int NUM_ADDR_BYTES = 2,
  parameter int GAP_CYCLES     = 1024,
  parameter int RESP_TIMEOUT   = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rw,
  input  logic [6:0]                  cmd_slave_id,
  input  logic [NUM_ADDR_BYTES*8-1:0] cmd_addr,
  input  logic [7:0]                  cmd_len,
  input  logic [7:0]                  wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  output logic                        tx_trig,
  output logic [7:0]                  send_data,
  input  logic                        tx_bsy,
  input  logic                        rx_data_valid,
  input  logic [7:0]                  rx_data_out,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int c_AW = NUM_ADDR_BYTES * 8;
  localparam int c_GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR   = 4'd1,
    S_ADDR  = 4'd2,
    S_LEN   = 4'd3,
    S_WDATA = 4'd4,
    S_RHDR  = 4'd5,
    S_RDATA = 4'd6,
    S_GAP   = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t          r_state;
  logic            r_rw;
  logic [6:0]      r_sid;
  logic [c_AW-1:0] r_addr;
  logic [7:0]      r_len;
  logic [8:0]      r_cnt;
  logic [c_GW-1:0] r_gap;
  logic            r_tx_trig;
  logic            r_hold;
  logic [7:0]      r_send_data;
  logic            r_wr_ready;
  logic            r_rd_valid;
  logic [7:0]      r_rd_data;
  logic            r_done;
  logic            r_err;

  // A new byte may go out only after the trigger cycle and one settle cycle.
  logic w_can_send;
  logic w_last;
  assign w_can_send = !tx_bsy && !r_tx_trig && !r_hold;
  assign w_last     = (r_cnt == {1'b0, r_len});

`ifdef REGMAP_MASTER_TIMEOUT_EN
  localparam int c_TW = $clog2(RESP_TIMEOUT + 1);
  logic [c_TW-1:0] r_to;
  logic            w_timeout;
  assign w_timeout = (r_to == c_TW'(RESP_TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rw        <= 1'b0;
      r_sid       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_tx_trig   <= 1'b0;
      r_hold      <= 1'b0;
      r_send_data <= '0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef REGMAP_MASTER_TIMEOUT_EN
      r_to        <= '0;
`endif
    end else begin
      r_tx_trig  <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_hold     <= r_tx_trig;
`ifdef REGMAP_MASTER_TIMEOUT_EN
      if (rx_data_valid || !(r_state == S_RHDR || r_state == S_RDATA))
        r_to <= '0;
      else
        r_to <= r_to + 1'b1;
`endif
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_rw    <= cmd_rw;
          r_sid   <= cmd_slave_id;
          r_addr  <= cmd_addr;
          r_len   <= cmd_len;
          r_err   <= 1'b0;
          r_state <= S_HDR;
        end
        S_HDR: if (w_can_send) begin
          r_send_data <= {r_rw, r_sid};
          r_tx_trig   <= 1'b1;
          r_cnt       <= '0;
          r_state     <= S_ADDR;
        end
        S_ADDR: if (w_can_send) begin
          r_send_data <= r_addr[c_AW-1 -: 8];
          r_addr      <= r_addr << 8;
          r_tx_trig   <= 1'b1;
          r_cnt       <= r_cnt + 1'b1;
          if (r_cnt == 9'(NUM_ADDR_BYTES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_LEN;
          end
        end
        S_LEN: if (w_can_send) begin
          r_send_data <= r_len;
          r_tx_trig   <= 1'b1;
          r_cnt       <= '0;
          r_state     <= r_rw ? S_RHDR : S_WDATA;
        end
        S_WDATA: if (wr_valid && w_can_send) begin
          r_send_data <= wr_data;
          r_tx_trig   <= 1'b1;
          r_wr_ready  <= 1'b1;
          r_cnt       <= r_cnt + 1'b1;
          if (w_last) r_state <= S_GAP;
        end
        S_RHDR: begin
          if (rx_data_valid) begin
            if (rx_data_out == {1'b1, r_sid}) begin
              r_cnt   <= '0;
              r_state <= S_RDATA;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_GAP;
            end
          end
`ifdef REGMAP_MASTER_TIMEOUT_EN
          else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_GAP;
          end
`endif
        end
        S_RDATA: begin
          if (rx_data_valid) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= rx_data_out;
            r_cnt      <= r_cnt + 1'b1;
            if (w_last) r_state <= S_GAP;
          end
`ifdef REGMAP_MASTER_TIMEOUT_EN
          else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_GAP;
          end
`endif
        end
        // The idle gap starts only once the last byte has left uart_tx.
        S_GAP: if (w_can_send) begin
          if (r_gap == c_GW'(GAP_CYCLES - 1)) begin
            r_gap   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign tx_trig   = r_tx_trig;
  assign send_data = r_send_data;
  assign wr_ready  = r_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/uart_regmap_master.md
Name: uart_regmap_master

Overview:
Host-side initiator for the UART byte regmap protocol. Turns one command (read/write, slave_id, address, byte count) into a framed byte stream for a uart_tx instance, and collects the responder's read reply from a uart_rx instance. Used by on-chip controllers and FPGA-to-FPGA bridges to access regmap slaves such as the block RAM.

Parameters:
NUM_ADDR_BYTES, 2, number of address bytes per frame, sent MSB first
GAP_CYCLES, 1024, idle clk cycles inserted after every frame so the responder's block timeout closes the frame
RESP_TIMEOUT, 65535, clk cycles allowed between received read bytes (used only with the optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high in IDLE only; a command is accepted on cmd_valid && cmd_ready
cmd_rw  input  1  1 = read, 0 = write
cmd_slave_id  input  7  target slave_id
cmd_addr  input  NUM_ADDR_BYTES*8  start address
cmd_len  input  8  byte count minus 1 (1..256 bytes)
wr_data  input  8  write data byte
wr_valid  input  1  write data available
wr_ready  output  1  one-cycle pulse when wr_data is consumed
rd_data  output  8  read data byte
rd_valid  output  1  one-cycle pulse per read byte
tx_trig  output  1  one-cycle send pulse to uart_tx
send_data  output  8  byte to transmit, stable while tx_trig is high
tx_bsy  input  1  uart_tx busy
rx_data_valid  input  1  byte-received strobe from uart_rx
rx_data_out  input  8  received byte
busy  output  1  high whenever the FSM is not IDLE
done  output  1  one-cycle pulse on completion
err  output  1  sticky error flag; cleared when the next command is accepted

Behaviour:
- Reset (synchronous, rst_n low at a clk edge): FSM goes to IDLE, all counters clear. Outputs: tx_trig=0, send_data=0, wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0, busy=0, cmd_ready=1 after reset is released. Reset mid-frame aborts without a done pulse. The responder recovers through its own block timeout.
- Command capture: on acceptance, rw, slave_id, addr and len are registered. Later changes on the cmd_* inputs are ignored.
- Byte send rule: tx_trig is asserted only when tx_bsy=0 and tx_trig was 0 in the previous cycle. After each trigger the FSM waits one cycle, then waits for tx_bsy=0 before sending the next byte.
- Frame layout: header {rw, slave_id}, then NUM_ADDR_BYTES address bytes MSB first, then the length byte. Write frames then carry len+1 data bytes. Read frames end after the length byte.
- States:
  - IDLE → HDR on command acceptance.
  - HDR → ADDR once the header byte is sent.
  - ADDR repeats NUM_ADDR_BYTES times, then → LEN.
  - LEN → WDATA if write, RHDR if read.
  - WDATA: wr_ready pulses when wr_valid=1 and a byte can be sent; the byte is sent the same cycle. No timeout on wr_valid. After len+1 bytes → GAP.
  - RHDR: waits for the first rx byte, which must equal {1, slave_id}. On mismatch set err and → GAP. On match → RDATA.
  - RDATA: each rx_data_valid produces rd_valid with rd_data=rx_data_out one cycle later. After len+1 bytes → GAP.
  - GAP: counts GAP_CYCLES, then → DONE.
  - DONE: pulses done for one cycle → IDLE.
- rx_data_valid outside RHDR/RDATA is ignored.
- Byte counter is 9 bits: len=255 gives 256 bytes, with no wrap.
- An rx_data_valid arriving on the same cycle as the RHDR→RDATA transition is not lost: the header is registered and the next byte is counted.

Optional Feature:
REGMAP_MASTER_TIMEOUT_EN:
- Defined: in RHDR/RDATA a counter reloads on every rx_data_valid. If RESP_TIMEOUT cycles pass without a byte, set err and → GAP.
- Undefined: the counter is absent and the FSM waits indefinitely for reply bytes.

Test Plan:
- Write: slave_id=1, addr=0x0123, len=2, data 0xA1,0xB2,0xC3 → tx sequence 0x01,0x01,0x23,0x02,0xA1,0xB2,0xC3; ≥GAP_CYCLES idle, then a single done pulse; err=0.
- Read: slave_id=1, addr=0x0010, len=1; bench replies 0x81,0x5A,0x3C → tx sequence 0x81,0x00,0x10,0x01; rd_valid pulses carry 0x5A then 0x3C; done pulses; err=0.
- Bad header: read with slave_id=1; bench replies 0x82 → err=1, no rd_valid, done pulses; next accepted command clears err.
- len=255 write → exactly 256 wr_ready pulses and 260 bytes transmitted.
- Back-pressure: tx_bsy held high 50 cycles mid-frame, and wr_valid low 20 cycles in WDATA → no dropped or duplicated bytes; tx_trig never asserted while tx_bsy=1.
- Reset mid-read (in RDATA after 1 byte) → next cycle busy=0, cmd_ready=1, no done pulse. With REGMAP_MASTER_TIMEOUT_EN defined, a silent responder gives err=1 RESP_TIMEOUT cycles after the last byte.
